uart_mat_frame_parser: RTL

//  Command/frame parser between UART receiver (rx_done pulse + rx_data) and matrix-multiply loader.

---
 rtl/uart_mat_frame_parser.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_mat_frame_parser.sv
// Frame parser between a UART receiver and the matrix-multiply loader: decodes the
// opcode and dimensions, answers ACK/NACK, then packs bytes into indexed FP32 words.
module uart_mat_frame_parser #(
    parameter logic [7:0]  OP_MATMUL   = 8'h02,
    parameter logic [7:0]  ACK_BYTE    = 8'hAA,
    parameter logic [7:0]  NACK_BYTE   = 8'h55,
    parameter int unsigned MAX_DIM     = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done_i,
    input  logic [7:0]  rx_data_i,
    output logic        tx_send_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_done_i,
    output logic        fp_valid_o,
    input  logic        fp_ready_i,
    output logic [31:0] fp_word_o,
    output logic        fp_mat_o,
    output logic [7:0]  fp_row_o,
    output logic [7:0]  fp_col_o,
    output logic [7:0]  dim_a_h_o,
    output logic [7:0]  dim_a_w_o,
    output logic [7:0]  dim_h_h_o,
    output logic [7:0]  dim_h_w_o,
    output logic        frame_done_o,
    output logic        err_dim_o,
    output logic        err_tmo_o,
    output logic        err_ovf_o
);

    localparam logic [7:0]  MaxDim  = 8'(MAX_DIM);
    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {StIdle, StDims, StCheck, StSendResp, StWaitTx, StLoad} state_e;

    state_e      state_q;
    logic [1:0]  dim_cnt_q, byte_cnt_q;
    logic [7:0]  dim_a_h_q, dim_a_w_q, dim_h_h_q, dim_h_w_q;
    logic [23:0] shift_q;
    logic [31:0] tmo_cnt_q, fp_word_q;
    logic        ack_q, all_rcvd_q, last_q;
    logic        cur_mat_q, fp_mat_q, fp_valid_q;
    logic [7:0]  cur_row_q, cur_col_q, fp_row_q, fp_col_q, tx_data_q;
    logic        tx_send_q, frame_done_q, err_dim_q, err_tmo_q, err_ovf_q;

    logic       dims_ok, counting, tmo_hit, slot_free, last_row, last_col;
    logic [7:0] cur_h, cur_w;

    always_comb begin
        dims_ok = (dim_a_h_q != 8'd0) && (dim_a_h_q <= MaxDim) &&
                  (dim_a_w_q != 8'd0) && (dim_a_w_q <= MaxDim) &&
                  (dim_h_h_q != 8'd0) && (dim_h_h_q <= MaxDim) &&
                  (dim_h_w_q != 8'd0) && (dim_h_w_q <= MaxDim) &&
                  (dim_a_w_q == dim_h_h_q);
        cur_h     = cur_mat_q ? dim_h_h_q : dim_a_h_q;
        cur_w     = cur_mat_q ? dim_h_w_q : dim_a_w_q;
        last_row  = (cur_row_q == cur_h - 8'd1);
        last_col  = (cur_col_q == cur_w - 8'd1);
        counting  = (state_q == StDims) || (state_q == StLoad);
        // A byte arriving in the expiry cycle takes priority over the timeout.
        tmo_hit   = counting && !rx_done_i && (tmo_cnt_q == TmoLast);
        slot_free = !fp_valid_q || fp_ready_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            dim_cnt_q    <= 2'd0;
            byte_cnt_q   <= 2'd0;
            dim_a_h_q    <= 8'd0;
            dim_a_w_q    <= 8'd0;
            dim_h_h_q    <= 8'd0;
            dim_h_w_q    <= 8'd0;
            shift_q      <= 24'd0;
            tmo_cnt_q    <= 32'd0;
            fp_word_q    <= 32'd0;
            ack_q        <= 1'b0;
            all_rcvd_q   <= 1'b0;
            last_q       <= 1'b0;
            cur_mat_q    <= 1'b0;
            cur_row_q    <= 8'd0;
            cur_col_q    <= 8'd0;
            fp_mat_q     <= 1'b0;
            fp_row_q     <= 8'd0;
            fp_col_q     <= 8'd0;
            fp_valid_q   <= 1'b0;
            tx_data_q    <= 8'd0;
            tx_send_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_dim_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            tx_send_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_dim_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
            tmo_cnt_q    <= (!counting || rx_done_i) ? 32'd0 : tmo_cnt_q + 32'd1;

            if (fp_valid_q && fp_ready_i) begin
                fp_valid_q <= 1'b0;
                if (last_q) begin
                    last_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                    state_q      <= StIdle;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (rx_done_i && rx_data_i == OP_MATMUL) begin
                        state_q   <= StDims;
                        dim_cnt_q <= 2'd0;
                        err_ovf_q <= 1'b0;
                    end
                end
                StDims: begin
                    if (tmo_hit) begin
                        err_tmo_q <= 1'b1;
                        state_q   <= StIdle;
                    end else if (rx_done_i) begin
                        unique case (dim_cnt_q)
                            2'd0: dim_a_h_q <= rx_data_i;
                            2'd1: dim_a_w_q <= rx_data_i;
                            2'd2: dim_h_h_q <= rx_data_i;
                            2'd3: dim_h_w_q <= rx_data_i;
                        endcase
                        dim_cnt_q <= dim_cnt_q + 2'd1;
                        if (dim_cnt_q == 2'd3) state_q <= StCheck;
                    end
                end
                StCheck: begin
                    ack_q      <= dims_ok;
                    err_dim_q  <= !dims_ok;
                    tx_data_q  <= dims_ok ? ACK_BYTE : NACK_BYTE;
                    cur_mat_q  <= 1'b0;
                    cur_row_q  <= 8'd0;
                    cur_col_q  <= 8'd0;
                    byte_cnt_q <= 2'd0;
                    all_rcvd_q <= 1'b0;
                    last_q     <= 1'b0;
                    state_q    <= StSendResp;
                end
                StSendResp: begin
                    tx_send_q <= 1'b1;
                    state_q   <= StWaitTx;
                end
                StWaitTx: begin
                    if (tx_done_i) state_q <= ack_q ? StLoad : StIdle;
                end
                StLoad: begin
                    if (tmo_hit) begin
                        err_tmo_q  <= 1'b1;
                        fp_valid_q <= 1'b0;
                        last_q     <= 1'b0;
                        state_q    <= StIdle;
                    end else if (rx_done_i && !all_rcvd_q) begin
                        if (byte_cnt_q != 2'd3) begin
                            shift_q    <= {shift_q[15:0], rx_data_i};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end else begin
                            byte_cnt_q <= 2'd0;
                            if (slot_free) begin
                                fp_word_q  <= {shift_q, rx_data_i};
                                fp_valid_q <= 1'b1;
                                fp_mat_q   <= cur_mat_q;
                                fp_row_q   <= cur_row_q;
                                fp_col_q   <= cur_col_q;
                                last_q     <= cur_mat_q && last_row && last_col;
                                if (last_col) begin
                                    cur_col_q <= 8'd0;
                                    if (last_row) begin
                                        cur_row_q <= 8'd0;
                                        if (cur_mat_q) all_rcvd_q <= 1'b1;
                                        else           cur_mat_q  <= 1'b1;
                                    end else begin
                                        cur_row_q <= cur_row_q + 8'd1;
                                    end
                                end else begin
                                    cur_col_q <= cur_col_q + 8'd1;
                                end
                            end else begin
                                err_ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_send_o    = tx_send_q;
    assign tx_data_o    = tx_data_q;
    assign fp_valid_o   = fp_valid_q;
    assign fp_word_o    = fp_word_q;
    assign fp_mat_o     = fp_mat_q;
    assign fp_row_o     = fp_row_q;
    assign fp_col_o     = fp_col_q;
    assign dim_a_h_o    = dim_a_h_q;
    assign dim_a_w_o    = dim_a_w_q;
    assign dim_h_h_o    = dim_h_h_q;
    assign dim_h_w_o    = dim_h_w_q;
    assign frame_done_o = frame_done_q;
    assign err_dim_o    = err_dim_q;
    assign err_tmo_o    = err_tmo_q;
    assign err_ovf_o    = err_ovf_q;

endmodule
